// File: rtl/rob_pkg.sv
// Shared sizing, packet and entry types for the reorder buffer.
// Tags are 1-based: tag 0 means "no tag / value lives in the regfile".
package rob_pkg;

   localparam int ROB_SZ = 8;
   localparam int TAG_W  = $clog2(ROB_SZ) + 1;
   localparam int PTR_W  = $clog2(ROB_SZ);
   localparam int CNT_W  = $clog2(ROB_SZ + 1);

   typedef struct packed {
      logic       has_dest;
      logic [4:0] dest_reg_idx;
   } DP_PACKET;

   typedef struct packed {
      logic [TAG_W-1:0] rob_tag;
      logic [31:0]      value;
   } CDB_PACKET;

   typedef struct packed {
      logic [TAG_W-1:0] rob_tag;
      logic             t_plus;
   } MAP_PACKET;

   typedef struct packed {
      MAP_PACKET map_packet_a;
      MAP_PACKET map_packet_b;
   } MAP_ROB_PACKET;

   typedef struct packed {
      logic [TAG_W-1:0] rob_tag;
      logic [4:0]       dest_reg_idx;
      logic             has_dest;
      logic [31:0]      value;
   } ROB_HEAD_PACKET;

   typedef struct packed {
      logic [TAG_W-1:0] rob_tag;
   } ROB_TAIL_PACKET;

   typedef struct packed {
      logic           retire_valid;
      ROB_HEAD_PACKET rob_head;
      ROB_TAIL_PACKET rob_new_tail;
   } ROB_MAP_PACKET;

   typedef struct packed {
      logic        valid;
      logic        complete;
      logic        has_dest;
      logic [4:0]  dest_reg_idx;
      logic [31:0] value;
   } ROB_ENTRY;

   function automatic logic [PTR_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
      logic [TAG_W-1:0] idx_full;
      idx_full = tag - TAG_W'(1);
      return idx_full[PTR_W-1:0];
   endfunction

   function automatic logic [TAG_W-1:0] idx_to_tag(input logic [PTR_W-1:0] idx);
      return TAG_W'(idx) + TAG_W'(1);
   endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer circular queue.
// Full and empty are derived from the registered count only.
module rob_ptr_ctrl
   import rob_pkg::*;
(
   input  logic             clock_i,
   input  logic             rst_n_i,
   input  logic             alloc_i,
   input  logic             retire_i,
   input  logic             flush_i,
   output logic [PTR_W-1:0] head_o,
   output logic [PTR_W-1:0] tail_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Pointers wrap naturally because ROB_SZ is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_i)  tail_d = tail_q + PTR_W'(1);
         if (retire_i) head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(alloc_i) - CNT_W'(retire_i);
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(ROB_SZ));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/rob.sv
// Reorder buffer: tag allocation, CDB capture, operand read and in-order retire.
// Optional ROB_SQUASH_EN adds a squash input that flushes the buffer after the head retires.
module rob
   import rob_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
`ifdef ROB_SQUASH_EN
   input  logic          squash,
`endif
   input  logic          dispatch_valid,
   input  DP_PACKET      dp_packet,
   input  CDB_PACKET     cdb_packet,
   input  MAP_ROB_PACKET map_rob_packet,
   output ROB_MAP_PACKET rob_map_packet,
   output logic [31:0]   rob_rs_value_a,
   output logic [31:0]   rob_rs_value_b,
   output logic          rob_full
);

   ROB_ENTRY         entry_q [ROB_SZ];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             full, empty, flush;
   logic             alloc_en, retire_en;
   logic [ROB_SZ-1:0] alloc_hit, retire_hit, cdb_hit;
   ROB_ENTRY         head_entry;

`ifdef ROB_SQUASH_EN
   assign flush = squash;
`else
   assign flush = 1'b0;
`endif

   assign head_entry = entry_q[head];
   assign retire_en  = !empty && head_entry.valid && head_entry.complete;
   assign alloc_en   = dispatch_valid && !full && !flush;

   rob_ptr_ctrl u_ptr (
      .clock_i  (clock),
      .rst_n_i  (reset),
      .alloc_i  (alloc_en),
      .retire_i (retire_en),
      .flush_i  (flush),
      .head_o   (head),
      .tail_o   (tail),
      .count_o  (count),
      .full_o   (full),
      .empty_o  (empty)
   );

   // CDB only lands on entries that are currently in flight.
   for (genvar gi = 0; gi < ROB_SZ; gi++) begin : g_hit
      assign alloc_hit[gi]  = alloc_en  && (tail == PTR_W'(gi));
      assign retire_hit[gi] = retire_en && (head == PTR_W'(gi));
      assign cdb_hit[gi]    = entry_q[gi].valid &&
                              (cdb_packet.rob_tag == TAG_W'(gi + 1));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ROB_SZ; i++) entry_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < ROB_SZ; i++) begin
            entry_q[i].valid    <= 1'b0;
            entry_q[i].complete <= 1'b0;
         end
      end else begin
         for (int i = 0; i < ROB_SZ; i++) begin
            if (alloc_hit[i]) begin
               entry_q[i].valid        <= 1'b1;
               entry_q[i].complete     <= 1'b0;
               entry_q[i].has_dest     <= dp_packet.has_dest;
               entry_q[i].dest_reg_idx <= dp_packet.dest_reg_idx;
            end else begin
               if (retire_hit[i]) entry_q[i].valid <= 1'b0;
               if (cdb_hit[i]) begin
                  entry_q[i].complete <= 1'b1;
                  entry_q[i].value    <= cdb_packet.value;
               end
            end
         end
      end
   end

   always_comb begin
      rob_map_packet                      = '0;
      rob_map_packet.retire_valid         = retire_en;
      rob_map_packet.rob_new_tail.rob_tag = idx_to_tag(tail);
      if (retire_en) begin
         rob_map_packet.rob_head.rob_tag      = idx_to_tag(head);
         rob_map_packet.rob_head.dest_reg_idx = head_entry.dest_reg_idx;
         rob_map_packet.rob_head.has_dest     = head_entry.has_dest;
         rob_map_packet.rob_head.value        = head_entry.value;
      end
   end

   assign rob_rs_value_a = (map_rob_packet.map_packet_a.t_plus &&
                            map_rob_packet.map_packet_a.rob_tag != '0) ?
                           entry_q[tag_to_idx(map_rob_packet.map_packet_a.rob_tag)].value : 32'h0;
   assign rob_rs_value_b = (map_rob_packet.map_packet_b.t_plus &&
                            map_rob_packet.map_packet_b.rob_tag != '0) ?
                           entry_q[tag_to_idx(map_rob_packet.map_packet_b.rob_tag)].value : 32'h0;

   assign rob_full = full;

   logic unused_count;
   assign unused_count = ^count;

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the reorder buffer.
// Build with +define+ROB_SQUASH_EN to also exercise the squash path.
module tb_rob;
   import rob_pkg::*;

   logic          clock;
   logic          reset;
   logic          dispatch_valid;
   DP_PACKET      dp_packet;
   CDB_PACKET     cdb_packet;
   MAP_ROB_PACKET map_rob_packet;
   ROB_MAP_PACKET rob_map_packet;
   logic [31:0]   rob_rs_value_a;
   logic [31:0]   rob_rs_value_b;
   logic          rob_full;
`ifdef ROB_SQUASH_EN
   logic          squash;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   rob dut (
      .clock          (clock),
      .reset          (reset),
`ifdef ROB_SQUASH_EN
      .squash         (squash),
`endif
      .dispatch_valid (dispatch_valid),
      .dp_packet      (dp_packet),
      .cdb_packet     (cdb_packet),
      .map_rob_packet (map_rob_packet),
      .rob_map_packet (rob_map_packet),
      .rob_rs_value_a (rob_rs_value_a),
      .rob_rs_value_b (rob_rs_value_b),
      .rob_full       (rob_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      dispatch_valid = 1'b0;
      dp_packet      = '0;
      cdb_packet     = '0;
      map_rob_packet = '0;
`ifdef ROB_SQUASH_EN
      squash         = 1'b0;
`endif
   endtask

   task automatic drive_dispatch(input logic [4:0] dest);
      dispatch_valid         = 1'b1;
      dp_packet.has_dest     = 1'b1;
      dp_packet.dest_reg_idx = dest;
   endtask

   task automatic drive_cdb(input int tag, input logic [31:0] val);
      cdb_packet.rob_tag = TAG_W'(tag);
      cdb_packet.value   = val;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #2;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0) begin n_bad++; $display("FAIL reset_retire_valid: got %0b want 0", rob_map_packet.retire_valid); end
      n_cmp++; if (rob_map_packet.rob_head !== '0) begin n_bad++; $display("FAIL reset_rob_head: got %h want 0", rob_map_packet.rob_head); end
      n_cmp++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) begin n_bad++; $display("FAIL reset_new_tail: got %0d want 1", rob_map_packet.rob_new_tail.rob_tag); end
      n_cmp++; if (rob_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b want 0", rob_full); end
      n_cmp++; if (rob_rs_value_a !== 32'h0 || rob_rs_value_b !== 32'h0) begin n_bad++; $display("FAIL reset_values: got a=%h b=%h want 0/0", rob_rs_value_a, rob_rs_value_b); end
      tick();
      reset = 1'b1;
      tick();
      $display("reset: released");
   endtask

   task automatic test_reset_midrun();
      for (int i = 0; i < 3; i++) begin
         idle(); drive_dispatch(5'(i + 1)); tick();
      end
      idle(); drive_cdb(1, 32'h11); tick();
      idle();
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b1) begin n_bad++; $display("FAIL midrun_pre_retire: got %0b want 1", rob_map_packet.retire_valid); end
      reset = 1'b0;
      #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_async_retire: got %0b want 0", rob_map_packet.retire_valid); end
      n_cmp++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) begin n_bad++; $display("FAIL midrun_async_tail: got %0d want 1", rob_map_packet.rob_new_tail.rob_tag); end
      #1;
      reset = 1'b1;
      tick();
      n_cmp++; if (dut.u_ptr.count_q !== '0) begin n_bad++; $display("FAIL midrun_count: got %0d want 0", dut.u_ptr.count_q); end
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_retire: got %0b want 0", rob_map_packet.retire_valid); end
      n_cmp++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) begin n_bad++; $display("FAIL midrun_tail: got %0d want 1", rob_map_packet.rob_new_tail.rob_tag); end
      n_cmp++; if (rob_full !== 1'b0) begin n_bad++; $display("FAIL midrun_full: got %0b want 0", rob_full); end
      $display("reset_midrun: 3 entries dropped");
   endtask

   task automatic test_inorder_retire();
      idle(); drive_dispatch(5'd5); #1;
      n_cmp++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd1) begin n_bad++; $display("FAIL inorder_tag1: got %0d want 1", rob_map_packet.rob_new_tail.rob_tag); end
      tick();
      idle(); drive_dispatch(5'd6); #1;
      n_cmp++; if (rob_map_packet.rob_new_tail.rob_tag !== 4'd2) begin n_bad++; $display("FAIL inorder_tag2: got %0d want 2", rob_map_packet.rob_new_tail.rob_tag); end
      tick();
      idle(); drive_cdb(2, 32'hBEEF); tick();
      idle(); drive_cdb(1, 32'h1234); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0) begin n_bad++; $display("FAIL inorder_no_bypass: got %0b want 0", rob_map_packet.retire_valid); end
      tick();
      idle(); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b1 || rob_map_packet.rob_head !== {4'd1, 5'd5, 1'b1, 32'h1234}) begin
         n_bad++; $display("FAIL inorder_retire1: got v=%0b head=%h want v=1 tag1 x5 1234", rob_map_packet.retire_valid, rob_map_packet.rob_head); end
      $display("retire: tag=%0d dest=x%0d value=%h", rob_map_packet.rob_head.rob_tag, rob_map_packet.rob_head.dest_reg_idx, rob_map_packet.rob_head.value);
      tick();
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b1 || rob_map_packet.rob_head !== {4'd2, 5'd6, 1'b1, 32'hBEEF}) begin
         n_bad++; $display("FAIL inorder_retire2: got v=%0b head=%h want v=1 tag2 x6 beef", rob_map_packet.retire_valid, rob_map_packet.rob_head); end
      $display("retire: tag=%0d dest=x%0d value=%h", rob_map_packet.rob_head.rob_tag, rob_map_packet.rob_head.dest_reg_idx, rob_map_packet.rob_head.value);
      tick();
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0 || rob_map_packet.rob_new_tail.rob_tag !== 4'd3) begin
         n_bad++; $display("FAIL inorder_empty: got v=%0b tail=%0d want v=0 tail=3", rob_map_packet.retire_valid, rob_map_packet.rob_new_tail.rob_tag); end
   endtask

   task automatic test_operand_read();
      idle(); drive_dispatch(5'd7); tick();
      idle(); drive_cdb(3, 32'hCAFE);
      map_rob_packet.map_packet_a = '{rob_tag: 4'd3, t_plus: 1'b1};
      #1;
      n_cmp++; if (rob_rs_value_a !== 32'h0) begin n_bad++; $display("FAIL operand_no_bypass: got %h want 0", rob_rs_value_a); end
      tick();
      idle();
      map_rob_packet.map_packet_a = '{rob_tag: 4'd3, t_plus: 1'b1};
      map_rob_packet.map_packet_b = '{rob_tag: 4'd3, t_plus: 1'b0};
      #1;
      n_cmp++; if (rob_rs_value_a !== 32'hCAFE) begin n_bad++; $display("FAIL operand_a_tplus: got %h want cafe", rob_rs_value_a); end
      n_cmp++; if (rob_rs_value_b !== 32'h0) begin n_bad++; $display("FAIL operand_b_no_tplus: got %h want 0", rob_rs_value_b); end
      map_rob_packet.map_packet_a.t_plus = 1'b0;
      map_rob_packet.map_packet_b.t_plus = 1'b1;
      #1;
      n_cmp++; if (rob_rs_value_a !== 32'h0) begin n_bad++; $display("FAIL operand_a_no_tplus: got %h want 0", rob_rs_value_a); end
      n_cmp++; if (rob_rs_value_b !== 32'hCAFE) begin n_bad++; $display("FAIL operand_b_tplus: got %h want cafe", rob_rs_value_b); end
      $display("operand: tag 3 value_a=%h value_b=%h", rob_rs_value_a, rob_rs_value_b);
      tick();
      idle();
   endtask

   task automatic test_full();
      // Head and tail both sit at index 3 here, so the first tag handed out is 4.
      for (int i = 0; i < ROB_SZ; i++) begin
         idle(); drive_dispatch(5'(i + 1)); #1;
         n_cmp++; if (rob_full !== 1'b0 || rob_map_packet.rob_new_tail.rob_tag !== TAG_W'(((3 + i) % 8) + 1)) begin
            n_bad++; $display("FAIL full_fill_%0d: got full=%0b tag=%0d want full=0 tag=%0d", i, rob_full, rob_map_packet.rob_new_tail.rob_tag, ((3 + i) % 8) + 1); end
         tick();
      end
      idle(); drive_dispatch(5'd31); #1;
      n_cmp++; if (rob_full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %0b want 1", rob_full); end
      tick();
      idle(); #1;
      n_cmp++; if (rob_full !== 1'b1 || rob_map_packet.rob_new_tail.rob_tag !== 4'd4) begin
         n_bad++; $display("FAIL full_dispatch_ignored: got full=%0b tag=%0d want full=1 tag=4", rob_full, rob_map_packet.rob_new_tail.rob_tag); end
      drive_cdb(4, 32'h44); tick();
      idle(); drive_dispatch(5'd30); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b1 || rob_map_packet.rob_head !== {4'd4, 5'd1, 1'b1, 32'h44} || rob_full !== 1'b1) begin
         n_bad++; $display("FAIL full_head_retire: got v=%0b head=%h full=%0b want v=1 tag4 x1 44 full=1", rob_map_packet.retire_valid, rob_map_packet.rob_head, rob_full); end
      tick();
      idle(); #1;
      n_cmp++; if (rob_full !== 1'b0 || rob_map_packet.rob_new_tail.rob_tag !== 4'd4 || rob_map_packet.retire_valid !== 1'b0) begin
         n_bad++; $display("FAIL full_after_retire: got full=%0b tag=%0d v=%0b want full=0 tag=4 v=0", rob_full, rob_map_packet.rob_new_tail.rob_tag, rob_map_packet.retire_valid); end
      $display("full: filled, retired one, rob_full=%0b", rob_full);
      reset = 1'b0; #1; reset = 1'b1;
      tick();
   endtask

   task automatic test_wrap();
      int n_ret;
      n_ret = 0;
      for (int c = 0; c < 23; c++) begin
         idle();
         if (c < 20) drive_dispatch(5'(c + 1));
         if (c >= 1 && c <= 20) drive_cdb(((c - 1) % 8) + 1, 32'h1000 + 32'(c - 1));
         #1;
         if (c < 20) begin
            n_cmp++; if (rob_map_packet.rob_new_tail.rob_tag !== TAG_W'((c % 8) + 1)) begin
               n_bad++; $display("FAIL wrap_alloc_%0d: got %0d want %0d", c, rob_map_packet.rob_new_tail.rob_tag, (c % 8) + 1); end
         end
         n_cmp++; if (rob_map_packet.retire_valid !== (c >= 2 && c <= 21)) begin
            n_bad++; $display("FAIL wrap_retire_valid_%0d: got %0b want %0b", c, rob_map_packet.retire_valid, (c >= 2 && c <= 21)); end
         if (rob_map_packet.retire_valid) begin
            n_ret++;
            n_cmp++; if (rob_map_packet.rob_head !== {TAG_W'(((c - 2) % 8) + 1), 5'(c - 1), 1'b1, 32'h1000 + 32'(c - 2)}) begin
               n_bad++; $display("FAIL wrap_head_%0d: got %h want tag%0d x%0d %h", c, rob_map_packet.rob_head, ((c - 2) % 8) + 1, c - 1, 32'h1000 + 32'(c - 2)); end
            $display("retire: tag=%0d dest=x%0d value=%h", rob_map_packet.rob_head.rob_tag, rob_map_packet.rob_head.dest_reg_idx, rob_map_packet.rob_head.value);
         end
         tick();
      end
      idle();
      n_cmp++; if (n_ret != 20) begin n_bad++; $display("FAIL wrap_retire_count: got %0d want 20", n_ret); end
   endtask

`ifdef ROB_SQUASH_EN
   task automatic test_squash();
      // Head/tail are at index 4 after the wrap run, so tags 5..8 are allocated.
      for (int i = 0; i < 4; i++) begin
         idle(); drive_dispatch(5'(i + 10)); tick();
      end
      idle(); drive_cdb(5, 32'h55); tick();
      idle(); squash = 1'b1; drive_dispatch(5'd20); drive_cdb(6, 32'h66); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b1 || rob_map_packet.rob_head !== {4'd5, 5'd10, 1'b1, 32'h55}) begin
         n_bad++; $display("FAIL squash_head_retire: got v=%0b head=%h want v=1 tag5 x10 55", rob_map_packet.retire_valid, rob_map_packet.rob_head); end
      tick();
      idle(); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0 || rob_map_packet.rob_new_tail.rob_tag !== 4'd1 || rob_full !== 1'b0 || dut.u_ptr.count_q !== '0) begin
         n_bad++; $display("FAIL squash_empty: got v=%0b tag=%0d full=%0b count=%0d want 0/1/0/0", rob_map_packet.retire_valid, rob_map_packet.rob_new_tail.rob_tag, rob_full, dut.u_ptr.count_q); end
      drive_dispatch(5'd9); tick();
      idle(); drive_cdb(6, 32'h66); tick();
      idle(); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b0) begin n_bad++; $display("FAIL squash_stale_cdb: got %0b want 0", rob_map_packet.retire_valid); end
      drive_cdb(1, 32'h99); tick();
      idle(); #1;
      n_cmp++; if (rob_map_packet.retire_valid !== 1'b1 || rob_map_packet.rob_head !== {4'd1, 5'd9, 1'b1, 32'h99}) begin
         n_bad++; $display("FAIL squash_refill: got v=%0b head=%h want v=1 tag1 x9 99", rob_map_packet.retire_valid, rob_map_packet.rob_head); end
      $display("squash: flushed, next tag=1 retired value=%h", rob_map_packet.rob_head.value);
      tick();
   endtask
`endif

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_reset_midrun();
      test_inorder_retire();
      test_operand_read();
      test_full();
      test_wrap();
`ifdef ROB_SQUASH_EN
      test_squash();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer, ROB_SZ entries, circular queue; sits directly downstream of the map table.
- Allocates a tag per dispatched instruction and supplies it to the map table in rob_map_packet.rob_new_tail.
- Captures CDB results and returns operand values for tags the map table marks t_plus.
- Retires in order, at most one per cycle, and reports each retirement to the map table (rob_map_packet.retire_valid / rob_head) and to the register file.

Parameters:
ROB_SZ, 8, number of entries; power of two, at least 2.
TAG_W, $clog2(ROB_SZ)+1, tag width; tag 0 is reserved as "no tag / value in regfile".

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
dispatch_valid  in  1  dispatch accepted by RS this cycle.
dp_packet  in  DP_PACKET  uses has_dest, dest_reg_idx[4:0].
cdb_packet  in  CDB_PACKET  rob_tag[TAG_W-1:0] plus value[31:0]; rob_tag==0 means idle.
map_rob_packet  in  MAP_ROB_PACKET  map_packet_a/b, each with rob_tag and t_plus.
rob_map_packet  out  ROB_MAP_PACKET  retire_valid; rob_head {rob_tag, dest_reg_idx, has_dest, value}; rob_new_tail {rob_tag}.
rob_rs_value_a  out  32  operand A value from the ROB.
rob_rs_value_b  out  32  operand B value from the ROB.
rob_full  out  1  no free entry; RS must not dispatch.

Behaviour:
- Entry i holds tag i+1 and the fields valid, complete, has_dest, dest_reg_idx, value.
- State: head_ptr and tail_ptr, each $clog2(ROB_SZ) bits, wrapping modulo ROB_SZ; count spans 0..ROB_SZ.
- Reset (reset==0, asynchronous): head=tail=count=0; all valid and complete bits cleared. Resulting outputs: retire_valid=0, rob_head=0, rob_new_tail.rob_tag=1, rob_full=0, value_a/b=0.
- rob_new_tail.rob_tag = tail_ptr+1, combinational. It is the tag the next dispatch receives; the map table writes it on the same edge.
- Dispatch: if dispatch_valid && !rob_full, then at the edge entry[tail] gets valid=1, complete=0, has_dest and dest_reg_idx; tail and count increment. dispatch_valid while full is ignored and is an assertion failure.
- rob_full = (count==ROB_SZ), from registered state only. A retire in the same cycle does not free a slot for that cycle's dispatch.
- CDB: if rob_tag!=0 and entry[rob_tag-1].valid, then at the edge complete=1 and value captured. A CDB tag that hits an invalid entry is ignored.
- Retire (combinational): retire_valid = entry[head].valid && entry[head].complete. rob_head presents tag head+1 and the entry fields.
- Retire (at the edge): entry[head].valid=0; head increments; count decrements.
- A CDB completing the head entry retires it the next cycle; there is no same-cycle bypass.
- Simultaneous dispatch and retire: count is unchanged, both pointers advance. Wrap from ROB_SZ-1 to 0 is seamless.
- Operand read: value_a = entry[map_packet_a.rob_tag-1].value when map_packet_a.t_plus && rob_tag!=0, else 0. value_b is identical using map_packet_b.
- Operand read adds no CDB bypass: the map table sets t_plus on the same edge the value lands.
- Empty: retire_valid=0. A CDB never targets the tag being allocated in that cycle.

Optional Feature:
- Macro: ROB_SQUASH_EN.
- When defined: adds input squash (1 bit).
- On squash, the head retire of that cycle still occurs, since the mispredicted branch at head is what raises squash.
- After that edge: all entries invalid, head=tail=count=0, rob_new_tail tag=1. Dispatch and CDB in the squash cycle are dropped.
- When undefined: the port is absent and there is no flush path.

Decomposition:
- Shared package sys_defs.svh holds: ROB_SZ, TAG_W, ROB_ENTRY typedef, ROB_MAP_PACKET, and the CDB_PACKET value field.
- One sub-module, rob_ptr_ctrl: head, tail and count registers plus the full/empty logic.
- The entry array and read muxes stay in rob.

Test Plan:
- Reset mid-run with 3 entries valid → next cycle count=0, retire_valid=0, rob_new_tail tag=1, rob_full=0.
- Dispatch dest x5, x6 (tags 1, 2); CDB tag 2 value 0xBEEF, then tag 1 value 0x1234 → tag 1 retires (x5, 0x1234) one cycle after its CDB; tag 2 (x6, 0xBEEF) retires the following cycle.
- Fill 8 entries → rob_full=1; a dispatch attempt changes nothing; retire 1 → rob_full=0 next cycle.
- Wrap: allocate and retire continuously for 20 instructions → tags cycle 1..8,1..; no lost or duplicated retirement.
- Operand read: tag 3 completed with 0xCAFE, map_packet_a {rob_tag 3, t_plus 1} → value_a=0xCAFE; with t_plus 0 → value_a=0.
- ROB_SQUASH_EN: 4 entries valid, head complete, squash=1 → head retires; next cycle ROB empty, rob_new_tail tag=1.
